// File: rtl/data_memory_responder_pkg.sv
// Shared types and helpers for the Memory-stage data-memory responder.
// Holds the FSM state encoding, the request bundle and the latency counter sizing.
package data_memory_responder_pkg;

   localparam int DMEM_CNT_W = 8;

   typedef enum logic [1:0] {
      DMEM_IDLE,
      DMEM_LOAD_WAIT,
      DMEM_STORE_WAIT
   } dmemState_;

   typedef struct packed {
      logic [31:0] address;
      logic [31:0] storeData;
      logic [3:0]  byteEnable;
   } dmemRequest_;

   // Countdown start value so the pulse lands exactly `latency` edges after capture.
   function automatic logic [DMEM_CNT_W-1:0] dmem_count_init(input int latency);
      return DMEM_CNT_W'(latency - 1);
   endfunction

   function automatic logic dmem_in_range(input logic [31:0] address, input int depth_words);
      return (32'(address[31:2]) < 32'(depth_words));
   endfunction

endpackage

// File: rtl/dmem_byte_ram.sv
// Word-addressed 32-bit RAM with four independent byte-lane write enables
// and a registered synchronous read port.
module dmem_byte_ram #(
   parameter int DEPTH_WORDS = 1024,
   parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
   input  logic             clock,
   input  logic             i_we,
   input  logic [3:0]       i_be,
   input  logic [IDX_W-1:0] i_idx,
   input  logic [31:0]      i_wdata,
   input  logic             i_re,
   output logic [31:0]      o_rdata
);

   logic [31:0] r_mem [DEPTH_WORDS];
   logic [31:0] r_rdata;

   // NOTE: the array and read register have no reset; contents must survive a reset and a
   // resettable array would not map onto block RAM.
   always_ff @(posedge clock) begin
      if (i_we) begin
         for (int b = 0; b < 4; b++) begin
            if (i_be[b]) begin
               // NOTE: non-blocking so a same-edge read returns the pre-write word, as a real RAM does.
               r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
            end
         end
      end
      if (i_re) begin
         r_rdata <= r_mem[i_idx];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/data_memory_responder.sv
// Responder end of the Memory-stage data-memory interface: one load or store at a time,
// serviced after a fixed latency and acknowledged with a single-cycle pulse.
module data_memory_responder
   import data_memory_responder_pkg::*;
#(
   parameter int DEPTH_WORDS   = 1024,
   parameter int LOAD_LATENCY  = 2,
   parameter int STORE_LATENCY = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] address,
   input  logic [31:0] storeData,
   input  logic [3:0]  byteEnable,
   input  logic        storeValid,
   input  logic        loadValid,
   output logic [31:0] loadData,
   output logic        loadDataValid,
   output logic        storeComplete,
   output logic        accessFault
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam logic [DMEM_CNT_W-1:0] LOAD_CNT_INIT  = dmem_count_init(LOAD_LATENCY);
   localparam logic [DMEM_CNT_W-1:0] STORE_CNT_INIT = dmem_count_init(STORE_LATENCY);

   dmemRequest_             w_req;
   dmemState_               r_state;
   logic [DMEM_CNT_W-1:0]   r_cnt;
   logic                    r_fault;

   logic                    w_idle;
   logic                    w_in_range;
   logic                    w_store_take;
   logic                    w_load_take;
   logic [IDX_W-1:0]        w_idx;
   logic [31:0]             w_rdata;
   logic                    w_unused;

   assign w_req = '{address: address, storeData: storeData, byteEnable: byteEnable};

   // Lane selection comes from byteEnable, so the byte offset bits carry no information.
   assign w_unused = &{1'b0, w_req.address[1:0]};

   // A reset edge must never commit a write, even if a request happens to be presented.
   assign w_idle       = (r_state == DMEM_IDLE) && reset;
   assign w_in_range   = dmem_in_range(w_req.address, DEPTH_WORDS);
   assign w_store_take = w_idle && storeValid;
   assign w_load_take  = w_idle && loadValid && !storeValid;
   assign w_idx        = w_req.address[IDX_W+1:2];

   dmem_byte_ram #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .IDX_W       (IDX_W)
   ) u_ram (
      .clock   (clock),
      .i_we    (w_store_take && w_in_range),
      .i_be    (w_req.byteEnable),
      .i_idx   (w_idx),
      .i_wdata (w_req.storeData),
      .i_re    (w_load_take && w_in_range),
      .o_rdata (w_rdata)
   );

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state       <= DMEM_IDLE;
         r_cnt         <= '0;
         r_fault       <= 1'b0;
         loadData      <= '0;
         loadDataValid <= 1'b0;
         storeComplete <= 1'b0;
         accessFault   <= 1'b0;
      end else begin
         loadDataValid <= 1'b0;
         storeComplete <= 1'b0;
         accessFault   <= 1'b0;
         case (r_state)
            DMEM_IDLE: begin
               if (storeValid) begin
                  r_state <= DMEM_STORE_WAIT;
                  r_cnt   <= STORE_CNT_INIT;
                  r_fault <= !w_in_range;
               end else if (loadValid) begin
                  r_state <= DMEM_LOAD_WAIT;
                  r_cnt   <= LOAD_CNT_INIT;
                  r_fault <= !w_in_range;
               end
            end
            DMEM_LOAD_WAIT: begin
               if (r_cnt == '0) begin
                  r_state       <= DMEM_IDLE;
                  loadDataValid <= 1'b1;
                  accessFault   <= r_fault;
                  loadData      <= r_fault ? 32'h0 : w_rdata;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            DMEM_STORE_WAIT: begin
               if (r_cnt == '0) begin
                  r_state       <= DMEM_IDLE;
                  storeComplete <= 1'b1;
                  accessFault   <= r_fault;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            default: r_state <= DMEM_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed self-checking bench for data_memory_responder (DEPTH 1024, load 2, store 1).
module tb_data_memory_responder;

   logic        clock;
   logic        reset;
   logic [31:0] address;
   logic [31:0] storeData;
   logic [3:0]  byteEnable;
   logic        storeValid;
   logic        loadValid;
   logic [31:0] loadData;
   logic        loadDataValid;
   logic        storeComplete;
   logic        accessFault;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] b2b_addr [3];
   logic [31:0] b2b_exp  [3];

   data_memory_responder #(
      .DEPTH_WORDS   (1024),
      .LOAD_LATENCY  (2),
      .STORE_LATENCY (1)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .address       (address),
      .storeData     (storeData),
      .byteEnable    (byteEnable),
      .storeValid    (storeValid),
      .loadValid     (loadValid),
      .loadData      (loadData),
      .loadDataValid (loadDataValid),
      .storeComplete (storeComplete),
      .accessFault   (accessFault)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Present one request, wait (bounded) for its pulse, check it, then drop the request.
   task automatic transact(input string tag, input logic st, input logic ld,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be, input int exp_lat,
                           input logic exp_fault, input logic [31:0] exp_rdata);
      int n;
      bit seen;
      @(negedge clock);
      address    = addr;
      storeData  = wdata;
      byteEnable = be;
      storeValid = st;
      loadValid  = ld;
      @(posedge clock);
      n    = 0;
      seen = 1'b0;
      while (!seen && n < 20) begin
         @(posedge clock);
         #1;
         n++;
         if (loadDataValid || storeComplete) seen = 1'b1;
      end
      check({tag, "_lat"}, n, exp_lat);
      check({tag, "_sc"}, 32'(storeComplete), 32'(st));
      check({tag, "_ldv"}, 32'(loadDataValid), 32'(!st));
      check({tag, "_fault"}, 32'(accessFault), 32'(exp_fault));
      if (!st) check({tag, "_data"}, loadData, exp_rdata);
      storeValid = 1'b0;
      loadValid  = 1'b0;
      @(posedge clock);
      #1;
      check({tag, "_one_cycle"}, {29'b0, loadDataValid, storeComplete, accessFault}, 32'h0);
   endtask

   task automatic expect_quiet(input string tag, input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(posedge clock);
         #1;
         check(tag, {30'b0, loadDataValid, storeComplete}, 32'h0);
      end
   endtask

   initial begin
      int  n;
      bit  seen;
      reset      = 1'b0;
      address    = '0;
      storeData  = '0;
      byteEnable = '0;
      storeValid = 1'b0;
      loadValid  = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      check("rst_loadData", loadData, 32'h0);
      check("rst_ldv", 32'(loadDataValid), 32'h0);
      check("rst_sc", 32'(storeComplete), 32'h0);
      check("rst_fault", 32'(accessFault), 32'h0);
      @(negedge clock);
      reset = 1'b1;

      transact("st_full", 1, 0, 32'h10, 32'hDEADBEEF, 4'b1111, 1, 0, 32'h0);
      transact("ld_full", 0, 1, 32'h10, 32'h0, 4'b0000, 2, 0, 32'hDEADBEEF);
      transact("st_part", 1, 0, 32'h10, 32'h00AA0000, 4'b0100, 1, 0, 32'h0);
      transact("ld_part", 0, 1, 32'h10, 32'h0, 4'b0000, 2, 0, 32'hDEAABEEF);
      transact("ld_oor", 0, 1, 32'h1000, 32'h0, 4'b0000, 2, 1, 32'h0);
      // 0x1010 aliases word 4 if the range check were missing.
      transact("st_oor", 1, 0, 32'h1010, 32'h12345678, 4'b1111, 1, 1, 32'h0);
      transact("ld_after_oor", 0, 1, 32'h10, 32'h0, 4'b0000, 2, 0, 32'hDEAABEEF);

      transact("st_and_ld", 1, 1, 32'h20, 32'h11223344, 4'b1111, 1, 0, 32'h0);
      expect_quiet("st_and_ld_no_load", 3);
      transact("ld_20", 0, 1, 32'h20, 32'h0, 4'b0000, 2, 0, 32'h11223344);
      transact("st_be0", 1, 0, 32'h20, 32'hFFFFFFFF, 4'b0000, 1, 0, 32'h0);
      transact("ld_be0", 0, 1, 32'h20, 32'h0, 4'b0000, 2, 0, 32'h11223344);

      transact("st_top", 1, 0, 32'hFFC, 32'hCAFEF00D, 4'b1111, 1, 0, 32'h0);
      transact("ld_top_off", 0, 1, 32'hFFF, 32'h0, 4'b0000, 2, 0, 32'hCAFEF00D);

      // loadValid toggles inside LOAD_WAIT; exactly one response must come back.
      @(negedge clock);
      address   = 32'h10;
      loadValid = 1'b1;
      @(posedge clock);
      #1 loadValid = 1'b0;
      @(posedge clock);
      #1 loadValid = 1'b1;
      @(posedge clock);
      #1;
      check("toggle_ldv", 32'(loadDataValid), 32'h1);
      check("toggle_data", loadData, 32'hDEAABEEF);
      loadValid = 1'b0;
      expect_quiet("toggle_no_extra", 4);

      // Reset one cycle after a load capture aborts it.
      @(negedge clock);
      address   = 32'h20;
      loadValid = 1'b1;
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      reset     = 1'b1;
      loadValid = 1'b0;
      check("midrst_loadData", loadData, 32'h0);
      check("midrst_outs", {29'b0, loadDataValid, storeComplete, accessFault}, 32'h0);
      expect_quiet("midrst_no_pulse", 4);
      transact("ld_after_rst", 0, 1, 32'h10, 32'h0, 4'b0000, 2, 0, 32'hDEAABEEF);

      // Back-to-back loads advanced on each pulse: one pulse every 3 cycles.
      b2b_addr[0] = 32'h10;  b2b_exp[0] = 32'hDEAABEEF;
      b2b_addr[1] = 32'h20;  b2b_exp[1] = 32'h11223344;
      b2b_addr[2] = 32'hFFC; b2b_exp[2] = 32'hCAFEF00D;
      @(negedge clock);
      address   = b2b_addr[0];
      loadValid = 1'b1;
      @(posedge clock);
      for (int k = 0; k < 3; k++) begin
         n    = 0;
         seen = 1'b0;
         while (!seen && n < 20) begin
            @(posedge clock);
            #1;
            n++;
            if (loadDataValid) seen = 1'b1;
         end
         check($sformatf("b2b_gap%0d", k), n, (k == 0) ? 32'd2 : 32'd3);
         check($sformatf("b2b_data%0d", k), loadData, b2b_exp[k]);
         if (k < 2) address = b2b_addr[k+1];
         else       loadValid = 1'b0;
      end
      expect_quiet("b2b_no_dup", 4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
